// File: rtl/cic_if.sv
// Sample stream into the CIC interpolator and its per-clock outputs.
interface cic_if #(parameter int IN_W = 8);
   logic [IN_W-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic            frame;
   logic [IN_W-1:0] out_data;
   logic            pdm_out;
   logic            underrun;

   modport master (output in_data, in_valid,
                   input  in_ready, frame, out_data, pdm_out, underrun);
   modport slave  (input  in_data, in_valid,
                   output in_ready, frame, out_data, pdm_out, underrun);
endinterface

// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator (x R) with a first-order delta-sigma PDM output.
// The stage count is structural: three combs and three integrators are built explicitly.
module cic_interpolator #(
   parameter int IN_W = 8,
   parameter int N    = 3,
   parameter int R    = 16
) (
   input logic   clk,
   input logic   rst_n,
   cic_if.slave  bus
);
   localparam int LOG2R   = $clog2(R);
   localparam int W       = IN_W + N*LOG2R;
   localparam int OUT_LSB = (N-1)*LOG2R;

   logic [LOG2R-1:0]      r_phase;
   logic [IN_W-1:0]       r_buf;
   logic                  r_buf_full;
   logic [IN_W-1:0]       r_hold;
   logic signed [W-1:0]   r_d1, r_d2, r_d3, r_cy;
   logic signed [W-1:0]   r_i1, r_i2, r_i3;
   logic [IN_W-1:0]       r_acc;
   logic                  r_pdm;
   logic                  r_underrun;

   logic                  w_load;
   logic                  w_accept;
   logic [IN_W-1:0]       w_s;
   logic signed [W-1:0]   w_s_ext, w_c1, w_c2, w_c3, w_u;
   logic [IN_W-1:0]       w_out;
   logic [IN_W:0]         w_sum;

   assign w_load   = (r_phase == LOG2R'(R-1));
   assign w_accept = bus.in_valid && !r_buf_full;

   // Slot sample priority: buffered sample, then same-edge bypass, then repeat.
   always_comb begin
      w_s = r_hold;
      if (r_buf_full)
         w_s = r_buf;
      else if (w_accept)
         w_s = bus.in_data;
   end

   assign w_s_ext = {{(W-IN_W){w_s[IN_W-1]}}, w_s};
   assign w_c1    = w_s_ext - r_d1;
   assign w_c2    = w_c1 - r_d2;
   assign w_c3    = w_c2 - r_d3;
   assign w_u     = (r_phase == '0) ? r_cy : '0;

   // Gain is R^(N-1), so dropping the low bits gives unity DC gain.
   assign w_out   = r_i3[OUT_LSB +: IN_W];
   assign w_sum   = {1'b0, r_acc} + {1'b0, ~w_out[IN_W-1], w_out[IN_W-2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_hold     <= '0;
         r_d1       <= '0;
         r_d2       <= '0;
         r_d3       <= '0;
         r_cy       <= '0;
         r_underrun <= 1'b0;
      end else begin
         r_phase <= r_phase + LOG2R'(1);
         if (w_load) begin
            r_buf_full <= 1'b0;
            r_hold     <= w_s;
            r_d1       <= w_s_ext;
            r_d2       <= w_c1;
            r_d3       <= w_c2;
            r_cy       <= w_c3;
            if (!r_buf_full && !bus.in_valid)
               r_underrun <= 1'b1;
         end else if (w_accept) begin
            r_buf      <= bus.in_data;
            r_buf_full <= 1'b1;
         end
      end
   end

   // Integrators and modulator run every clock; wrap-around is intended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i1  <= '0;
         r_i2  <= '0;
         r_i3  <= '0;
         r_acc <= '0;
         r_pdm <= 1'b0;
      end else begin
         r_i1  <= r_i1 + w_u;
         r_i2  <= r_i2 + r_i1;
         r_i3  <= r_i3 + r_i2;
         r_acc <= w_sum[IN_W-1:0];
         r_pdm <= w_sum[IN_W];
      end
   end

   assign bus.in_ready = !r_buf_full;
   assign bus.frame    = w_load;
   assign bus.out_data = w_out;
   assign bus.pdm_out  = r_pdm;
   assign bus.underrun = r_underrun;
endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator: the driver queues expectations keyed to clock
// ticks, and the monitor checks them on the falling edge.
module tb_cic_interpolator;
   logic clk;
   logic rst_n;
   int   tick  = 0;
   int   tick0 = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pdm_ones = 0;
   logic [7:0] prev_out = 8'h00;

   typedef enum {K_OUT, K_RDY, K_FRM, K_UND, K_PDM, K_PCLR, K_PCNT, K_MONO} kind_t;
   typedef struct {
      int    cyc;
      kind_t kind;
      int    exp;
      int    tol;
   } sb_t;
   sb_t sb[$];

   cic_if #(.IN_W(8)) bus ();

   cic_interpolator #(.IN_W(8), .N(3), .R(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) tick <= tick + 1;

   task automatic push(input int cyc, input kind_t kd, input int ex, input int tol);
      sb_t e;
      e.cyc = cyc; e.kind = kd; e.exp = ex; e.tol = tol;
      sb.push_back(e);
   endtask

   task automatic exp_at(input int kk, input kind_t kd, input int ex, input int tol);
      push(tick0 + kk, kd, ex, tol);
   endtask

   task automatic exp_range(input int k0, input int k1, input kind_t kd, input int ex);
      for (int k = k0; k <= k1; k++) push(tick0 + k, kd, ex, 0);
   endtask

   task automatic to_k(input int target);
      while ((tick - tick0) < target) @(negedge clk);
   endtask

   always @(negedge clk) begin
      int  act;
      bit  ok;
      bit  is_check;
      pdm_ones += int'(bus.pdm_out);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == tick) begin
            is_check = 1'b1;
            act = 0;
            ok  = 1'b0;
            case (sb[i].kind)
               K_OUT:  begin act = int'(bus.out_data); ok = (act == sb[i].exp); end
               K_RDY:  begin act = int'(bus.in_ready); ok = (act == sb[i].exp); end
               K_FRM:  begin act = int'(bus.frame);    ok = (act == sb[i].exp); end
               K_UND:  begin act = int'(bus.underrun); ok = (act == sb[i].exp); end
               K_PDM:  begin act = int'(bus.pdm_out);  ok = (act == sb[i].exp); end
               K_PCNT: begin
                  act = pdm_ones;
                  ok  = (act >= sb[i].exp - sb[i].tol) && (act <= sb[i].exp + sb[i].tol);
               end
               K_MONO: begin
                  act = int'($signed(bus.out_data));
                  ok  = (act <= int'($signed(prev_out)));
               end
               default: begin pdm_ones = 0; is_check = 1'b0; end
            endcase
            if (is_check) begin
               n_checks++;
               if (ok) n_pass++;
               else if (sb[i].kind == K_MONO)
                  $display("FAIL %s at tick %0d: out_data rose to %0d from %0d",
                           sb[i].kind.name(), tick, act, int'($signed(prev_out)));
               else
                  $display("FAIL %s at tick %0d: got %0d, expected %0d (tol %0d)",
                           sb[i].kind.name(), tick, act, sb[i].exp, sb[i].tol);
            end
            sb.delete(i);
         end else if (sb[i].cyc < tick) begin
            n_checks++;
            $display("FAIL %s expired: tick %0d never checked", sb[i].kind.name(), sb[i].cyc);
            sb.delete(i);
         end
      end
      prev_out = bus.out_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got tick %0d", tick);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(negedge clk);

      // Reset held with random inputs.
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = 8'($urandom);
         push(tick + 1, K_OUT, 0, 0);
         push(tick + 1, K_RDY, 1, 0);
         push(tick + 1, K_FRM, 0, 0);
         push(tick + 1, K_UND, 0, 0);
         push(tick + 1, K_PDM, 0, 0);
         @(negedge clk);
      end

      // Release; positive DC 0x40 supplied continuously.
      rst_n        = 1'b1;
      tick0        = tick;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40;
      exp_at(1,  K_RDY, 0, 0);
      exp_at(1,  K_PDM, 0, 0);
      exp_at(2,  K_PDM, 1, 0);
      exp_at(3,  K_PDM, 0, 0);
      exp_at(14, K_FRM, 0, 0);
      exp_at(15, K_FRM, 1, 0);
      exp_at(16, K_FRM, 0, 0);
      exp_at(16, K_RDY, 1, 0);
      exp_at(17, K_RDY, 0, 0);
      exp_at(31, K_FRM, 1, 0);
      exp_range(67, 340, K_OUT, 'h40);
      exp_at(80,  K_PCLR, 0, 0);
      exp_at(336, K_PCNT, 192, 1);
      exp_at(340, K_UND, 0, 0);

      // Settle at 0x7F, then step to 0x80 (-128).
      to_k(352);
      bus.in_data = 8'h7F;
      exp_range(420, 448, K_OUT, 'h7F);
      to_k(432);
      bus.in_data = 8'h80;
      for (int k = 449; k <= 499; k++) exp_at(k, K_MONO, 0, 0);
      exp_range(500, 760, K_OUT, 'h80);
      exp_at(500, K_PCLR, 0, 0);
      exp_at(756, K_PCNT, 0, 1);
      exp_at(760, K_UND, 0, 0);

      // Backpressure: 0x10 waits in the buffer, 0x20 stalls until the next load drains it.
      to_k(768);
      bus.in_data = 8'h10;
      exp_range(769, 783, K_RDY, 0);
      exp_at(784, K_RDY, 1, 0);
      exp_range(785, 799, K_RDY, 0);
      exp_range(800, 940, K_RDY, 1);
      exp_range(852, 940, K_OUT, 'h20);
      exp_at(896, K_UND, 0, 0);
      exp_at(911, K_UND, 0, 0);
      exp_at(912, K_UND, 1, 0);
      exp_at(940, K_UND, 1, 0);
      to_k(769);
      bus.in_data = 8'h20;
      to_k(785);
      bus.in_valid = 1'b0;

      // Bypass: valid only during frame cycles, then input stops.
      for (int m = 0; m < 6; m++) begin
         to_k(815 + 16*m);
         bus.in_valid = 1'b1;
         to_k(816 + 16*m);
         bus.in_valid = 1'b0;
      end

      // Half-cycle reset pulse while phase is 7.
      to_k(966);
      @(posedge clk);
      #1 rst_n = 1'b0;
      push(tick, K_OUT, 0, 0);
      push(tick, K_RDY, 1, 0);
      push(tick, K_FRM, 0, 0);
      push(tick, K_UND, 0, 0);
      push(tick, K_PDM, 0, 0);
      #5 rst_n = 1'b1;
      tick0 = tick;
      exp_range(1, 10, K_OUT, 0);
      exp_at(1,  K_PDM, 0, 0);
      exp_at(2,  K_PDM, 1, 0);
      exp_at(14, K_FRM, 0, 0);
      exp_at(15, K_FRM, 1, 0);
      exp_at(15, K_UND, 0, 0);
      exp_at(16, K_UND, 1, 0);

      to_k(20);
      repeat (3) @(negedge clk);
      while (sb.size() > 0) begin
         n_checks++;
         $display("FAIL %s pending: tick %0d never reached", sb[0].kind.name(), sb[0].cyc);
         void'(sb.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
